// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack memory port and
// hands them to the decoder over valid/ready. One instruction in flight at a time.
module instr_fetch #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = {ADDRESS_WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_ack,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     PCsrc,
    input  logic [ADDRESS_WIDTH-1:0] ImmOp,
    output logic [ADDRESS_WIDTH-1:0] PC,
    output logic                     misaligned
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = {{(ADDRESS_WIDTH-3){1'b0}}, 3'b100};

    state_e                   state_q;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0]    instr_q;
    logic                     valid_q;
    logic                     req_q;
    logic                     misaligned_q;
    logic [ADDRESS_WIDTH-1:0] next_pc_d;

    // Candidate next PC; modulo arithmetic, wrap-around is legal.
    always_comb begin
        next_pc_d = pc_q + PC_STEP;
        if (PCsrc) begin
            next_pc_d = pc_q + ImmOp;
        end else begin
            next_pc_d = pc_q + PC_STEP;
        end
    end

    // Fetch FSM; all outputs are registered. req_q is cleared on reset so the first
    // request appears only once rst has been released, and an ack is only honoured
    // while our own request is up.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= {DATA_WIDTH{1'b0}};
            valid_q      <= 1'b0;
            req_q        <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (req_q && imem_ack) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= ST_VALID;
                    end else begin
                        req_q   <= 1'b1;
                    end
                end
                ST_VALID: begin
                    if (valid_q && instr_ready) begin
                        valid_q <= 1'b0;
                        if (next_pc_d[1:0] != 2'b00) begin
                            misaligned_q <= 1'b1;
                            req_q        <= 1'b0;
                            state_q      <= ST_HALT;
                        end else begin
                            pc_q    <= next_pc_d;
                            req_q   <= 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end else begin
                        req_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign PC          = pc_q;
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected {PC, instr} on each accept,
// a monitor pops and compares whenever the decoder side accepts an instruction.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCsrc;
    logic [31:0] ImmOp;
    logic [31:0] PC;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    logic        mem_en;
    int          mem_wait;

    instr_fetch #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .RESET_PC     (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .PCsrc      (PCsrc),
        .ImmOp      (ImmOp),
        .PC         (PC),
        .misaligned (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0004: mem_word = 32'h0010_0113;
            default:       mem_word = {a[15:0], 16'h0013};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Instruction memory: acks mem_wait cycles after the request is seen
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!mem_en) begin
                cnt = 0;
            end else if (imem_req) begin
                if (cnt >= mem_wait) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    cnt        = 0;
                end else begin
                    imem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                cnt      = 0;
            end
        end
    end

    // Monitor: every accepted instruction is compared against the scoreboard
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL accept_unexpected actual=%h_%h expected=none", PC, instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({PC, instr} !== e) begin
                    errors++;
                    $display("FAIL accept_pc_instr actual=%h_%h expected=%h_%h",
                             PC, instr, e[63:32], e[31:0]);
                end
            end
        end
    end

    // Wait for a presented instruction, then accept it with the given branch decision
    task automatic take(input logic src, input logic [31:0] imm);
        int n;
        n = 0;
        while (!instr_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!instr_valid) begin
            errors++;
            $display("FAIL valid_timeout actual=0 expected=1");
        end
        instr_ready = 1'b1;
        PCsrc       = src;
        ImmOp       = imm;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        PCsrc       = 1'b0;
        ImmOp       = 32'h0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        PCsrc       = 1'b0;
        ImmOp       = 32'h0;
        mem_en      = 1'b1;
        mem_wait    = 0;

        // Reset state
        cycle();
        cycle();
        chk("rst_pc", PC, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        rst = 1'b0;

        // 1: zero-wait fetch, valid two cycles after release
        cycle();
        chk("t1_req", {31'h0, imem_req}, 32'h1);
        chk("t1_addr", imem_addr, 32'h0);
        cycle();
        chk("t1_valid", {31'h0, instr_valid}, 32'h1);
        chk("t1_instr", instr, 32'h0050_0093);
        mem_wait = 3;
        exp_q.push_back({32'h0, 32'h0050_0093});
        take(1'b0, 32'h0);

        // 2: three-cycle memory latency, address held until ack
        for (int i = 0; i < 4; i++) begin
            chk("t2_addr_stable", imem_addr, 32'h4);
            chk("t2_req_held", {31'h0, imem_req}, 32'h1);
            chk("t2_not_valid", {31'h0, instr_valid}, 32'h0);
            cycle();
        end
        chk("t2_valid_after_ack", {31'h0, instr_valid}, 32'h1);
        mem_wait = 0;

        // 4: decoder stall with PCsrc/ImmOp wiggling
        for (int i = 0; i < 5; i++) begin
            PCsrc = i[0];
            ImmOp = 32'h100;
            chk("t4_valid", {31'h0, instr_valid}, 32'h1);
            chk("t4_pc", PC, 32'h4);
            chk("t4_instr", instr, 32'h0010_0113);
            chk("t4_req", {31'h0, imem_req}, 32'h0);
            cycle();
        end
        PCsrc = 1'b0;
        ImmOp = 32'h0;
        exp_q.push_back({32'h4, 32'h0010_0113});
        take(1'b1, 32'h0000_000C);
        chk("t4_branch_addr", imem_addr, 32'h10);

        // 3: backward and forward branches
        exp_q.push_back({32'h10, 32'h0010_0013});
        take(1'b1, 32'hFFFF_FFF8);
        chk("t3_back_addr", imem_addr, 32'h08);
        exp_q.push_back({32'h08, 32'h0008_0013});
        take(1'b1, 32'h0000_0008);
        chk("t3_fwd_addr0", imem_addr, 32'h10);
        exp_q.push_back({32'h10, 32'h0010_0013});
        take(1'b1, 32'h0000_000C);
        chk("t3_fwd_addr", imem_addr, 32'h1C);
        exp_q.push_back({32'h1C, 32'h001C_0013});
        take(1'b0, 32'h0);
        chk("t3_seq_addr", imem_addr, 32'h20);

        // 5: misaligned target halts; stray ack and ready are ignored
        exp_q.push_back({32'h20, 32'h0020_0013});
        take(1'b1, 32'h0000_0006);
        mem_en      = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_misaligned", {31'h0, misaligned}, 32'h1);
            chk("t5_valid", {31'h0, instr_valid}, 32'h0);
            chk("t5_req", {31'h0, imem_req}, 32'h0);
            chk("t5_pc", PC, 32'h20);
            cycle();
        end
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        mem_en      = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t5_rst_misaligned", {31'h0, misaligned}, 32'h0);
        chk("t5_rst_pc", PC, 32'h0);

        // 6: reset while a slow fetch is outstanding, late ack discarded
        mem_wait = 3;
        cycle();
        cycle();
        chk("t6_req_pending", {31'h0, imem_req}, 32'h1);
        mem_en     = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst        = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_rst_req", {31'h0, imem_req}, 32'h0);
        chk("t6_rst_pc", PC, 32'h0);
        cycle();
        chk("t6_late_ack_valid", {31'h0, instr_valid}, 32'h0);
        chk("t6_late_ack_instr", instr, 32'h0);
        imem_ack = 1'b0;
        mem_wait = 0;
        mem_en   = 1'b1;
        exp_q.push_back({32'h0, 32'h0050_0093});
        take(1'b1, 32'hFFFF_FFFC);
        chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
        exp_q.push_back({32'hFFFF_FFFC, 32'hFFFC_0013});
        take(1'b0, 32'h0);
        chk("t6_wrap_addr", imem_addr, 32'h0);
        chk("t6_wrap_misaligned", {31'h0, misaligned}, 32'h0);
        exp_q.push_back({32'h0, 32'h0050_0093});
        take(1'b0, 32'h0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            cycle();
        end
        chk("scoreboard_drained", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
